// File: rtl/player_select_if.sv
// Handshake bundle between the game controller and one human player front end.
// The controller opens the window and reads back the chosen code.
interface player_select_if;
   logic       en;
   logic       sel;
   logic       conf;
   logic [1:0] choice;
   logic       locked;
   logic       locked_pulse;

   modport master (
      output en,
      output sel,
      output conf,
      input  choice,
      input  locked,
      input  locked_pulse
   );

   modport slave (
      input  en,
      input  sel,
      input  conf,
      output choice,
      output locked,
      output locked_pulse
   );
endinterface

// File: rtl/player_select.sv
// Human player front end: synchronises and debounces sel/conf, cycles a choice code
// on sel presses and locks it on a conf press while the selection window is open.
module player_select #(
   parameter int unsigned DEBOUNCE_CYCLES = 1000000,
   parameter int unsigned NUM_CHOICES     = 3
) (
   input logic            clk,
   input logic            rst,
   player_select_if.slave bus
);

   localparam int unsigned      CNT_W       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_LAST    = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]       CHOICE_LAST = 2'(NUM_CHOICES - 1);

   typedef enum logic [1:0] {
      StIdle,
      StSelect,
      StLocked
   } state_e;

   // Button vectors: bit 0 is sel, bit 1 is conf.
   logic [1:0]       raw;
   logic [1:0]       sync1_q;
   logic [1:0]       sync2_q;
   logic [1:0]       db_q;
   logic [1:0]       db_d;
   logic [1:0]       db_prev_q;
   logic [1:0]       press_q;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];

   logic             sel_press;
   logic             conf_press;

   state_e           state_q;
   state_e           state_d;
   logic [1:0]       choice_q;
   logic [1:0]       choice_d;
   logic             pulse_q;
   logic             pulse_d;

   assign raw        = {bus.conf, bus.sel};
   assign sel_press  = press_q[0];
   assign conf_press = press_q[1];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1_q   <= '0;
         sync2_q   <= '0;
         db_q      <= '0;
         db_prev_q <= '0;
         press_q   <= '0;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
      end else begin
         sync1_q   <= raw;
         sync2_q   <= sync1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         press_q   <= db_q & ~db_prev_q;
         cnt_q[0]  <= cnt_d[0];
         cnt_q[1]  <= cnt_d[1];
      end
   end

   // The counter only runs while the synced level disagrees with the debounced one,
   // so any return to the debounced level restarts the qualification window.
   always_comb begin
      db_d = db_q;
      for (int b = 0; b < 2; b++) begin
         cnt_d[b] = '0;
         if (sync2_q[b] != db_q[b]) begin
            if (cnt_q[b] == CNT_LAST) begin
               db_d[b] = sync2_q[b];
            end else begin
               cnt_d[b] = cnt_q[b] + CNT_W'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         choice_q <= '0;
         pulse_q  <= 1'b0;
      end else begin
         state_q  <= state_d;
         choice_q <= choice_d;
         pulse_q  <= pulse_d;
      end
   end

   // A closed window overrides any press; conf beats sel when both arrive together.
   always_comb begin
      state_d  = state_q;
      choice_d = choice_q;
      pulse_d  = 1'b0;
      if (!bus.en) begin
         state_d = StIdle;
      end else begin
         unique case (state_q)
            StIdle: begin
               state_d  = StSelect;
               choice_d = '0;
            end
            StSelect: begin
               if (conf_press) begin
                  state_d = StLocked;
                  pulse_d = 1'b1;
               end else if (sel_press) begin
                  choice_d = (choice_q == CHOICE_LAST) ? 2'd0 : choice_q + 2'd1;
               end
            end
            StLocked: begin
               state_d = StLocked;
            end
            default: begin
               state_d = StIdle;
            end
         endcase
      end
   end

   assign bus.choice       = choice_q;
   assign bus.locked       = (state_q == StLocked);
   assign bus.locked_pulse = pulse_q;

endmodule

// File: doc/player_select.md
Name: player_select

Overview:
- Human-player front end for the lab4 two-player choice game. One instance per player.
- Synchronises and debounces the raw sel/conf buttons.
- Cycles a 2-bit choice through the NUM_CHOICES legal values on each sel press, and locks it on a conf press.
- Presents a locked choice to the downstream round logic, in the same 2-bit format the CPU player drives.

Parameters:
- DEBOUNCE_CYCLES, 1000000: consecutive cycles a synchronised button must differ from its debounced state before that state flips (10 ms at 100 MHz). Minimum 2. Set to 4 in simulation.
- NUM_CHOICES, 3: number of legal choice codes, 0..NUM_CHOICES-1. Must be ≤ 4.

Ports:
- clk  in  1  system clock
- rst  in  1  reset; asynchronous, active-high
- en  in  1  selection window open, driven by the game controller
- sel  in  1  raw, asynchronous sel button
- conf  in  1  raw, asynchronous confirm button
- choice  out  2  current or locked choice code
- locked  out  1  high while the choice is locked
- locked_pulse  out  1  one-cycle strobe on the lock event

Behaviour:
- Reset (async, rst=1): all flops cleared; choice=0, locked=0, locked_pulse=0; FSM=IDLE; debounce counters=0; debounced states=0. Reset mid-operation aborts immediately, with no partial lock.
- Synchroniser: two flops per button. If raw is sampled high at edge k, the synced value s is high after edge k+1.
- Debounce, per button:
  - Counter is 0 whenever s == db.
  - While s != db, the counter increments each edge.
  - On the edge where s != db and cnt == DEBOUNCE_CYCLES-1: db <= s and cnt <= 0.
  - Any return of s to db before that edge clears cnt, so glitches shorter than DEBOUNCE_CYCLES cycles are ignored.
- Press detect: registered rising edge of db; the press flag is high for exactly one cycle. Falling edges are ignored.
- End-to-end latency: raw high sampled at edge k → db=1 after edge k+1+DEBOUNCE_CYCLES → press=1 after edge k+2+DEBOUNCE_CYCLES → choice/locked update after edge k+3+DEBOUNCE_CYCLES.
- FSM states: IDLE, SELECT, LOCKED.
  - IDLE: choice holds its last value, locked=0. If en=1: go to SELECT and set choice <= 0.
  - SELECT:
    - sel_press only: choice <= choice+1, wrapping NUM_CHOICES-1 → 0.
    - conf_press: go to LOCKED, locked <= 1, locked_pulse <= 1 for one cycle. choice is unchanged.
    - sel_press and conf_press in the same cycle: conf wins. Lock the current choice; no increment.
  - LOCKED: sel and conf presses are ignored; choice is frozen; locked=1.
  - en=0 in any state: next state IDLE, locked <= 0, no pulse. en takes priority over presses in the same cycle.
- en has no effect on debouncing: buttons are always debounced.
- A button held down produces one press only. A press already pending when en rises is not acted on if it occurs before the SELECT transition.
- choice never holds a value ≥ NUM_CHOICES.
- Width rule: choice is always 2 bits. Increment wraps modulo NUM_CHOICES, not modulo 4.

Test Plan (DEBOUNCE_CYCLES=4, NUM_CHOICES=3):
- Reset: assert rst mid-cycle while in LOCKED with choice=2 → outputs go to 0 immediately without a clock edge; after release, FSM is IDLE.
- Cycling and wrap:
  - en=1, then four clean sel presses (each held 10 cycles, released 10 cycles) → choice sequence 1, 2, 0, 1.
  - Each change occurs exactly 7 edges after the raw rise.
- Glitch rejection: sel pulsed high for 3 cycles, then low → choice unchanged; sel held 4+ cycles → single increment.
- Lock:
  - conf press with choice=2 → locked=1 and locked_pulse=1 for exactly one cycle, 7 edges after the raw rise.
  - Further sel/conf presses leave choice=2 and produce no pulse.
- Simultaneous press: sel and conf rise on the same edge with choice=1 → LOCKED with choice=1, no increment.
- Window close/reopen:
  - en drops while in SELECT with choice=2 → locked=0, presses ignored.
  - en rises again → choice=0 one cycle later; a held-down conf does not re-lock until released and pressed again.
